// File: rtl/ringosc_freq_meter.sv
// ringosc_freq_meter: enables a ring oscillator, waits for it to settle, then counts
// its synchronized rising edges over a programmable window of clk cycles.
module ringosc_freq_meter #(
   parameter int GATE_W        = 16,
   parameter int CNT_W         = 16,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              osc_in,
   output logic              osc_enable,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
   state_t              state_q, state_d;
   logic [2:0]          sync_q, sync_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [GATE_W-1:0]   gate_n_q, gate_n_d;
   logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                osc_enable_q, osc_enable_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rise;
   // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the delayed copy for edge detect
   assign rise = sync_q[1] & ~sync_q[2];
   always_comb begin
      state_d    = state_q;
      sync_d     = {sync_q[1:0], osc_in};
      settle_d   = settle_q;
      gate_n_d   = gate_n_q;
      gate_cnt_d = gate_cnt_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            state_d  = SETTLE;
            gate_n_d = (gate_cycles == '0) ? '0 : gate_cycles - GATE_W'(1);
            count_d  = '0;
            ovf_d    = 1'b0;
            settle_d = '0;
         end
         SETTLE: if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d    = MEASURE;
            gate_cnt_d = '0;
         end else settle_d = settle_q + SW'(1);
         MEASURE: begin
            if (rise) begin
               if (&count_q) ovf_d = 1'b1;
               else count_d = count_q + CNT_W'(1);
            end
            if (gate_cnt_q == gate_n_q) state_d = DONE;
            else gate_cnt_d = gate_cnt_q + GATE_W'(1);
         end
         default: state_d = IDLE;
      endcase
      osc_enable_d = (state_d == SETTLE) || (state_d == MEASURE);
      busy_d       = state_d != IDLE;
      done_d       = state_d == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sync_q       <= '0;
         settle_q     <= '0;
         gate_n_q     <= '0;
         gate_cnt_q   <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         osc_enable_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         settle_q     <= settle_d;
         gate_n_q     <= gate_n_d;
         gate_cnt_q   <= gate_cnt_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         osc_enable_q <= osc_enable_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end
   assign osc_enable = osc_enable_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign count      = count_q;
   assign overflow   = ovf_q;
endmodule
